// File: rtl/video_timing_gen.sv
// Raster timing generator and pixel-fetch sequencer feeding the DVI encoder.
// Scans one fixed mode, issues fetch addresses and realigns returned RGB with the sync/DE timing.
module video_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int RD_LATENCY = 2   // legal range 1..8
) (
  input  logic        pixel_clk,
  input  logic        gpuclk_rst_b,
  input  logic        enable,
  output logic        fetch_en,
  output logic [10:0] fetch_x,
  output logic [10:0] fetch_y,
  input  logic [23:0] fetch_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_b,
  output logic [7:0]  pixel_r,
  output logic [7:0]  pixel_g,
  output logic [7:0]  pixel_b,
  output logic        frame_start,
  output logic        line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  // ST_ARM is the one-cycle gap between accepting enable and scanning pixel 0,0.
  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN} state_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
    logic ls;
  } ctl_t;

  state_t      state;
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [10:0] x_hold;
  logic [10:0] y_hold;
  logic        run;
  ctl_t        ctl_raw;
  ctl_t        ctl_tail;
  ctl_t        ctl_dly [RD_LATENCY];

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pixel_clk or negedge gpuclk_rst_b) begin
    if (!gpuclk_rst_b) begin
      state <= ST_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (enable) state <= ST_ARM;
        ST_ARM:  state <= ST_RUN;
        ST_RUN: begin
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
              v_cnt <= '0;
              // Stopping is only possible here, so frames are never truncated.
              if (!enable) state <= ST_IDLE;
            end else begin
              v_cnt <= v_cnt + 11'd1;
            end
          end else begin
            h_cnt <= h_cnt + 11'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign run      = (state == ST_RUN);
  assign fetch_en = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);

  always_ff @(posedge pixel_clk or negedge gpuclk_rst_b) begin
    if (!gpuclk_rst_b) begin
      x_hold <= '0;
      y_hold <= '0;
    end else if (fetch_en) begin
      x_hold <= h_cnt;
      y_hold <= v_cnt;
    end
  end

  assign fetch_x = fetch_en ? h_cnt : x_hold;
  assign fetch_y = fetch_en ? v_cnt : y_hold;

  assign ctl_raw.hs = run && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign ctl_raw.vs = run && (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign ctl_raw.de = fetch_en;
  assign ctl_raw.fs = fetch_en && (h_cnt == 11'd0) && (v_cnt == 11'd0);
  assign ctl_raw.ls = fetch_en && (h_cnt == 11'd0);

  // NOTE: the delay line is a handful of flops, so it is reset to idle rather than left to flush.
  always_ff @(posedge pixel_clk or negedge gpuclk_rst_b) begin
    if (!gpuclk_rst_b) begin
      for (int i = 0; i < RD_LATENCY; i++) ctl_dly[i] <= '0;
    end else begin
      ctl_dly[0] <= ctl_raw;
      for (int i = 1; i < RD_LATENCY; i++) ctl_dly[i] <= ctl_dly[i-1];
    end
  end

  assign ctl_tail = ctl_dly[RD_LATENCY-1];

  // Output register: the returned RGB for a fetch lands here on the same edge as its timing bits.
  always_ff @(posedge pixel_clk or negedge gpuclk_rst_b) begin
    if (!gpuclk_rst_b) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      blank_b     <= 1'b0;
      pixel_r     <= '0;
      pixel_g     <= '0;
      pixel_b     <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      hsync       <= ctl_tail.hs ? HS_POL : ~HS_POL;
      vsync       <= ctl_tail.vs ? VS_POL : ~VS_POL;
      blank_b     <= ctl_tail.de;
      {pixel_r, pixel_g, pixel_b} <= ctl_tail.de ? fetch_rgb : 24'h0;
      frame_start <= ctl_tail.fs;
      line_start  <= ctl_tail.ls;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three instances (default mode, and a tiny mode at two read latencies)
// checked every cycle against a frame-position model, plus hand-computed timing points.
module tb_video_timing_gen;

  localparam int NI = 3;
  localparam int LAT [NI] = '{2, 1, 8};
  localparam int HA  [NI] = '{640, 8, 8};
  localparam int HFP [NI] = '{16, 2, 2};
  localparam int HSY [NI] = '{96, 3, 3};
  localparam int HBP [NI] = '{48, 2, 2};
  localparam int VA  [NI] = '{480, 4, 4};
  localparam int VFP [NI] = '{10, 1, 1};
  localparam int VSY [NI] = '{2, 2, 2};
  localparam int VBP [NI] = '{33, 1, 1};
  localparam int SMALL_FRAME = 15 * 8;

  typedef struct packed {
    logic de, hs, vs, fs, ls;
    logic [10:0] x, y;
  } rec_t;

  typedef struct packed {
    logic        fetch_en;
    logic [10:0] fetch_x, fetch_y;
    logic        hsync, vsync, blank_b;
    logic [23:0] rgb;
    logic        fs, ls;
  } obs_t;

  logic clk;
  logic en    [NI];
  logic rst_b [NI];
  obs_t act   [NI];
  obs_t exp_o [NI];

  int vecs = 0;
  int miss = 0;
  int cyc  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame position: -2 idle, -1 the gap cycle after enable is accepted, >=0 raster index.
  function automatic int next_pos(input int pos, input logic e, input int frame);
    if (pos == -2) return e ? -1 : -2;
    if (pos == -1) return 0;
    if (pos == frame - 1) return e ? 0 : -2;
    return pos + 1;
  endfunction

  function automatic rec_t rec_of(input int pos, input rec_t prev, input int ht, input int ha,
                                  input int hfp, input int hsy, input int va, input int vfp,
                                  input int vsy);
    rec_t r;
    int h, v;
    r   = '0;
    r.x = prev.x;
    r.y = prev.y;
    if (pos >= 0) begin
      h    = pos % ht;
      v    = pos / ht;
      r.de = (h < ha) && (v < va);
      r.hs = (h >= ha + hfp) && (h < ha + hfp + hsy);
      r.vs = (v >= va + vfp) && (v < va + vfp + vsy);
      r.fs = r.de && (pos == 0);
      r.ls = r.de && (h == 0);
      if (r.de) begin
        r.x = 11'(h);
        r.y = 11'(v);
      end
    end
    return r;
  endfunction

  function automatic obs_t to_obs(input rec_t s0, input rec_t o);
    obs_t r;
    r.fetch_en = s0.de;
    r.fetch_x  = s0.x;
    r.fetch_y  = s0.y;
    r.hsync    = ~o.hs;
    r.vsync    = ~o.vs;
    r.blank_b  = o.de;
    r.rgb      = o.de ? {o.x[7:0], o.y[7:0], 8'hA5} : 24'h0;
    r.fs       = o.fs;
    r.ls       = o.ls;
    return r;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g
    localparam int L  = LAT[gi];
    localparam int HT = HA[gi] + HFP[gi] + HSY[gi] + HBP[gi];
    localparam int VT = VA[gi] + VFP[gi] + VSY[gi] + VBP[gi];
    localparam int FR = HT * VT;

    logic        rb, e;
    logic        fe, hs, vs, bb, fs, ls;
    logic [10:0] fx, fy;
    logic [23:0] frgb;
    logic [7:0]  pr, pg, pb;
    logic [24:0] rd_pipe [L];
    int          pos;
    rec_t        q [L+2];

    assign rb = rst_b[gi];
    assign e  = en[gi];

    video_timing_gen #(
      .H_ACTIVE(HA[gi]), .H_FP(HFP[gi]), .H_SYNC(HSY[gi]), .H_BP(HBP[gi]),
      .V_ACTIVE(VA[gi]), .V_FP(VFP[gi]), .V_SYNC(VSY[gi]), .V_BP(VBP[gi]),
      .HS_POL(1'b0), .VS_POL(1'b0), .RD_LATENCY(L)
    ) dut (
      .pixel_clk(clk), .gpuclk_rst_b(rb), .enable(e),
      .fetch_en(fe), .fetch_x(fx), .fetch_y(fy), .fetch_rgb(frgb),
      .hsync(hs), .vsync(vs), .blank_b(bb),
      .pixel_r(pr), .pixel_g(pg), .pixel_b(pb),
      .frame_start(fs), .line_start(ls)
    );

    // Renderer stand-in: answers each fetch L cycles later, junk when nothing was fetched.
    always @(posedge clk) begin
      rd_pipe[0] <= {fe, fx[7:0], fy[7:0], 8'hA5};
      for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign frgb = rd_pipe[L-1][24] ? rd_pipe[L-1][23:0] : 24'h3CC35A;

    always @(posedge clk or negedge rb) begin
      if (!rb) begin
        pos <= -2;
        for (int k = 0; k < L + 2; k++) q[k] <= '0;
      end else begin
        pos  <= next_pos(pos, e, FR);
        q[0] <= rec_of(next_pos(pos, e, FR), q[0], HT, HA[gi], HFP[gi], HSY[gi],
                       VA[gi], VFP[gi], VSY[gi]);
        for (int k = 1; k < L + 2; k++) q[k] <= q[k-1];
      end
    end

    assign act[gi]   = {fe, fx, fy, hs, vs, bb, pr, pg, pb, fs, ls};
    assign exp_o[gi] = to_obs(q[0], q[L+1]);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vecs++;
    if (got !== want) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) check($sformatf("model_dut%0d", i), act[i], exp_o[i]);
  endtask

  int   fs_cyc [NI];
  int   fe0_cyc, bb0_cyc;
  logic bb0_fs;
  logic [23:0] bb0_rgb;

  task automatic measure_start(input logic [NI-1:0] mask);
    int t0;
    t0 = cyc;
    fe0_cyc = -1;
    bb0_cyc = -1;
    for (int i = 0; i < NI; i++) fs_cyc[i] = -1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (act[0].fetch_en && fe0_cyc < 0) fe0_cyc = cyc;
      if (act[0].blank_b && bb0_cyc < 0) begin
        bb0_cyc = cyc;
        bb0_fs  = act[0].fs;
        bb0_rgb = act[0].rgb;
      end
      for (int i = 0; i < NI; i++) if (act[i].fs && fs_cyc[i] < 0) fs_cyc[i] = cyc;
    end
    for (int i = 0; i < NI; i++)
      if (mask[i]) check($sformatf("start_latency%0d", i), fs_cyc[i] - t0, LAT[i] + 3);
  endtask

  initial begin
    obs_t idle_o;
    int   t0, rel, r, bb_cnt, ls_cnt, idle_act;
    int   sb [NI], sl [NI], sv [NI], sv_first [NI];

    idle_o = '0;
    idle_o.hsync = 1'b1;
    idle_o.vsync = 1'b1;
    for (int i = 0; i < NI; i++) begin
      en[i] = 1'b0;
      rst_b[i] = 1'b0;
      sb[i] = 0; sl[i] = 0; sv[i] = 0; sv_first[i] = -1;
    end
    repeat (3) tick();
    for (int i = 0; i < NI; i++) rst_b[i] = 1'b1;
    repeat (20) tick();
    check("idle_hsync", act[0].hsync, 1);
    check("idle_vsync", act[0].vsync, 1);
    check("idle_blank", act[0].blank_b, 0);
    check("idle_pixel", act[0].rgb, 0);
    check("idle_fetch", act[0].fetch_en, 0);

    for (int i = 0; i < NI; i++) en[i] = 1'b1;
    measure_start(3'b111);
    check("fetch_to_blank", bb0_cyc - fe0_cyc, 3);
    check("first_pixel_fs", bb0_fs, 1);
    check("first_pixel_rgb", bb0_rgb, 24'h0000A5);

    // Default mode over lines 1..5; tiny mode over its second frame.
    t0 = bb0_cyc;
    bb_cnt = 0;
    ls_cnt = 0;
    while (cyc < t0 + 4642) begin
      tick();
      rel = cyc - t0;
      if (rel >= 800 && rel < 1600) bb_cnt += int'(act[0].blank_b);
      if (rel >= 800) ls_cnt += int'(act[0].ls);
      if (rel == 1455) check("hsync_before", act[0].hsync, 1);
      if (rel == 1456) check("hsync_first", act[0].hsync, 0);
      if (rel == 1551) check("hsync_last", act[0].hsync, 0);
      if (rel == 1552) check("hsync_after", act[0].hsync, 1);
      if (rel == 4639) begin
        check("px639_line5", act[0].rgb, 24'h7F05A5);
        check("px639_blank", act[0].blank_b, 1);
      end
      if (rel == 4640) check("px640_blank", act[0].blank_b, 0);
      for (int i = 1; i < NI; i++) begin
        r = cyc - fs_cyc[i] - SMALL_FRAME;
        if (r >= 0 && r < SMALL_FRAME) begin
          sb[i] += int'(act[i].blank_b);
          sl[i] += int'(act[i].ls);
          if (!act[i].vsync) begin
            sv[i]++;
            if (sv_first[i] < 0) sv_first[i] = r;
          end
        end
      end
    end
    check("line_de_count", bb_cnt, 640);
    check("line_start_count", ls_cnt, 5);
    for (int i = 1; i < NI; i++) begin
      check($sformatf("frame_de%0d", i), sb[i], 32);
      check($sformatf("frame_ls%0d", i), sl[i], 4);
      check($sformatf("vsync_len%0d", i), sv[i], 30);
      check($sformatf("vsync_at%0d", i), sv_first[i], 75);
    end

    // Short enable glitch, then a full drop; the model decides whether the frame boundary was hit.
    en[1] = 1'b0;
    repeat (4) tick();
    en[1] = 1'b1;
    repeat (50) tick();
    en[1] = 1'b0;
    en[2] = 1'b0;
    repeat (260) tick();
    idle_act = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      idle_act += int'(act[1].blank_b) + int'(act[2].blank_b) + int'(act[1].fetch_en) +
                  int'(act[2].fetch_en) + int'(!act[1].hsync) + int'(!act[2].hsync);
    end
    check("idle_after_drop", idle_act, 0);
    en[1] = 1'b1;
    en[2] = 1'b1;
    measure_start(3'b110);
    repeat (200) tick();

    // Asynchronous reset in the middle of a line.
    for (int k = 0; k < 300 && g[1].pos != 35; k++) tick();
    check("reset_point", g[1].pos, 35);
    @(posedge clk);
    #3;
    for (int i = 0; i < NI; i++) begin
      rst_b[i] = 1'b0;
      en[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < NI; i++) check($sformatf("async_reset%0d", i), act[i], idle_o);
    repeat (3) tick();
    for (int i = 0; i < NI; i++) rst_b[i] = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < NI; i++) en[i] = 1'b1;
    measure_start(3'b111);
    repeat (400) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
